alu_op_sequencer: RTL

Initiator side of the 4-bit ALU interface. Accepts operation requests (operands + opcode) over a valid/ready handshake and drives the combinational ALU's num1/num2/opcode from registers. Captures result and N/Z/C/V flags one cycle later and returns them over a valid/ready response channel. Keeps sticky flag and completed-op counters for the surrounding datapath/controller.

---
 rtl/alu_seq_pkg.sv | 22 ++
 rtl/alu_op_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_OR  = 2'b10,
        OP_AND = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_op_sequencer.sv
// Initiator for the external combinational ALU: registers a request into the
// ALU inputs, captures result/flags one cycle later and returns them.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [1:0]        req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic [3:0]        sticky_flags,
    input  logic              sticky_clr,
    output logic [CNT_W-1:0]  op_count,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    output logic [1:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              alu_negative,
    input  logic              alu_zero
);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_num1;
    logic [DATA_W-1:0] r_num2;
    logic [1:0]        r_opcode;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        r_flags;
    logic [3:0]        r_sticky;
    logic [CNT_W-1:0]  r_count;

    logic              w_accept;
    logic              w_capture;
    logic              w_done;
    logic [3:0]        w_flags;
    logic [3:0]        w_sticky_base;

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_capture = (r_state == EXEC);
    assign w_done    = (r_state == RESP) && rsp_ready;

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_N] = alu_negative;
        w_flags[FLAG_Z] = alu_zero;
        w_flags[FLAG_C] = alu_carry;
        w_flags[FLAG_V] = alu_overflow;
    end

    // A clear coinciding with capture wipes the old value before the OR.
    assign w_sticky_base = sticky_clr ? '0 : r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num1   <= '0;
            r_num2   <= '0;
            r_opcode <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_sticky <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_num1   <= req_a;
                r_num2   <= req_b;
                r_opcode <= req_op;
            end
            if (w_capture) begin
                r_result <= alu_result;
                r_flags  <= w_flags;
                r_sticky <= w_sticky_base | w_flags;
            end else if (sticky_clr) begin
                r_sticky <= '0;
            end
            if (w_done) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign rsp_valid    = (r_state == RESP);
    assign rsp_result   = r_result;
    assign rsp_flags    = r_flags;
    assign sticky_flags = r_sticky;
    assign op_count     = r_count;
    assign alu_num1     = r_num1;
    assign alu_num2     = r_num2;
    assign alu_opcode   = r_opcode;

endmodule
